// File: rtl/alu.sv
// Four-function ALU (ADD/SUB/AND/OR) with combinational result/flags and a one-cycle registered copy.
// Optional build macro ALU_SAT_EN enables saturating ADD/SUB.
module alu #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [1:0]         sel_i,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   output logic [width_p-1:0] res_o,
   output logic               carry_o,
   output logic               zero_o,
   output logic               neg_o,
   output logic               ovf_o,
   output logic [width_p-1:0] res_r_o,
   output logic [3:0]         flags_r_o
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   localparam int MSB = width_p - 1;

   op_e              op;
   logic [width_p:0] sum;
   logic [width_p:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [MSB:0]     raw;

   assign op   = op_e'(sel_i);
   // Extra top bit holds carry-out for ADD and borrow for SUB.
   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign diff = {1'b0, a_i} - {1'b0, b_i};

   assign add_ovf = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
   assign sub_ovf = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);

   always_comb begin
      raw     = '0;
      carry_o = 1'b0;
      ovf_o   = 1'b0;
      unique case (op)
         OP_ADD: begin
            raw     = sum[MSB:0];
            carry_o = sum[width_p];
            ovf_o   = add_ovf;
         end
         OP_SUB: begin
            raw     = diff[MSB:0];
            carry_o = diff[width_p];
            ovf_o   = sub_ovf;
         end
         OP_AND:  raw = a_i & b_i;
         OP_OR:   raw = a_i | b_i;
         default: raw = '0;
      endcase
   end

`ifdef ALU_SAT_EN
   // Unsigned carry clamp takes priority over the signed clamp when both fire;
   // carry_o/ovf_o keep reporting the pre-saturation condition.
   logic [MSB:0] smax;
   logic [MSB:0] smin;

   always_comb begin
      smax      = '1;
      smax[MSB] = 1'b0;
      smin      = '0;
      smin[MSB] = 1'b1;
      res_o     = raw;
      if (op == OP_ADD) begin
         if (sum[width_p])
            res_o = '1;
         else if (add_ovf)
            res_o = a_i[MSB] ? smin : smax;
      end else if (op == OP_SUB) begin
         if (diff[width_p])
            res_o = '0;
      end
   end
`else
   assign res_o = raw;
`endif

   assign zero_o = (res_o == '0);
   assign neg_o  = res_o[MSB];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         res_r_o   <= '0;
         flags_r_o <= 4'b0000;
      end else begin
         res_r_o   <= res_o;
         flags_r_o <= {carry_o, zero_o, neg_o, ovf_o};
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (default build, width_p = 8).
module tb_alu;

   logic       clk;
   logic       reset;
   logic [1:0] sel;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] res;
   logic       carry;
   logic       zero;
   logic       neg;
   logic       ovf;
   logic [7:0] res_r;
   logic [3:0] flags_r;

   int checks = 0;
   int errors = 0;

   alu #(.width_p(8)) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .sel_i     (sel),
      .a_i       (a),
      .b_i       (b),
      .res_o     (res),
      .carry_o   (carry),
      .zero_o    (zero),
      .neg_o     (neg),
      .ovf_o     (ovf),
      .res_r_o   (res_r),
      .flags_r_o (flags_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply operands just after a rising edge, then let combinational logic settle.
   task automatic drive(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y);
      sel = s;
      a   = x;
      b   = y;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      sel   = 2'b00;
      a     = 8'h00;
      b     = 8'h00;
      tick();
      drive(2'b00, 8'h05, 8'h02);
      chk("comb_during_reset", {24'd0, res}, 32'h07);
      tick();
      chk("reset_res_r", {24'd0, res_r}, 32'h00);
      chk("reset_flags_r", {28'd0, flags_r}, 32'h0);
      reset = 1'b0;

      // 1 + 3
      drive(2'b00, 8'h01, 8'h03);
      chk("add_res", {24'd0, res}, 32'h04);
      chk("add_flags", {28'd0, carry, zero, neg, ovf}, 32'h0);
      tick();
      chk("add_res_r", {24'd0, res_r}, 32'h04);
      chk("add_flags_r", {28'd0, flags_r}, 32'h0);

      // 1 - 3 borrows, negative, no signed overflow
      drive(2'b01, 8'h01, 8'h03);
      chk("sub_res", {24'd0, res}, 32'hFE);
      chk("sub_flags", {28'd0, carry, zero, neg, ovf}, 32'hA);

      drive(2'b10, 8'h0F, 8'h3C);
      chk("and_res", {24'd0, res}, 32'h0C);
      chk("and_flags", {28'd0, carry, zero, neg, ovf}, 32'h0);
      drive(2'b11, 8'h0F, 8'h3C);
      chk("or_res", {24'd0, res}, 32'h3F);
      chk("or_carry", {31'd0, carry}, 32'h0);

      // wrap-around and signed overflow boundaries
      drive(2'b00, 8'hFF, 8'h01);
      chk("wrap_res", {24'd0, res}, 32'h00);
      chk("wrap_flags", {28'd0, carry, zero, neg, ovf}, 32'hC);
      drive(2'b00, 8'h7F, 8'h01);
      chk("addovf_res", {24'd0, res}, 32'h80);
      chk("addovf_flags", {28'd0, carry, zero, neg, ovf}, 32'h3);
      drive(2'b01, 8'h80, 8'h01);
      chk("subovf_res", {24'd0, res}, 32'h7F);
      chk("subovf_flags", {28'd0, carry, zero, neg, ovf}, 32'h1);
      drive(2'b01, 8'h33, 8'h33);
      chk("subzero_flags", {28'd0, carry, zero, neg, ovf}, 32'h4);
      drive(2'b10, 8'hF0, 8'h80);
      chk("and_neg_flags", {28'd0, carry, zero, neg, ovf}, 32'h2);

      // back-to-back ops: registered copy lags by one cycle
      tick();
      drive(2'b00, 8'h01, 8'h03);
      tick();
      chk("pipe0_res_r", {24'd0, res_r}, 32'h04);
      drive(2'b01, 8'h01, 8'h03);
      tick();
      chk("pipe1_res_r", {24'd0, res_r}, 32'hFE);
      chk("pipe1_flags_r", {28'd0, flags_r}, 32'hA);
      drive(2'b10, 8'h01, 8'h03);
      tick();
      chk("pipe2_res_r", {24'd0, res_r}, 32'h01);
      drive(2'b11, 8'h01, 8'h03);
      tick();
      chk("pipe3_res_r", {24'd0, res_r}, 32'h03);
      chk("pipe3_flags_r", {28'd0, flags_r}, 32'h0);

      // mid-stream reset drops the in-flight value, comb path unaffected
      drive(2'b00, 8'hFF, 8'h01);
      tick();
      chk("pre_rst_flags_r", {28'd0, flags_r}, 32'hC);
      drive(2'b00, 8'h05, 8'h02);
      reset = 1'b1;
      #1;
      chk("rst_comb_res", {24'd0, res}, 32'h07);
      tick();
      chk("rst_res_r", {24'd0, res_r}, 32'h00);
      chk("rst_flags_r", {28'd0, flags_r}, 32'h0);
      reset = 1'b0;
      drive(2'b01, 8'h01, 8'h03);
      chk("post_rst_comb", {24'd0, res}, 32'hFE);
      tick();
      chk("post_rst_res_r", {24'd0, res_r}, 32'hFE);
      chk("post_rst_flags_r", {28'd0, flags_r}, 32'hA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
